// File: rtl/srec_pkg.sv
// Shared constants, FSM state type and hex/checksum helpers for the S-record emitter.
package srec_pkg;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_3  = 8'h33;
  localparam logic [7:0] ASCII_7  = 8'h37;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_CNT,
    ST_ADDR,
    ST_RD,
    ST_DATA,
    ST_CK,
    ST_EOL,
    ST_TERM,
    ST_FIN
  } state_t;

  // Uppercase hex: 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 == 8'h37)
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    return (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
  endfunction

  function automatic logic [7:0] srec_cksum(input logic [7:0] acc);
    return ~acc;
  endfunction

endpackage

// File: rtl/srec_char_reg.sv
// Valid/ready output holding register: a loaded character is held until the sink accepts it.
module srec_char_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       char_ready,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       free
);

  // A new character may enter when the register is empty or its current one leaves this edge
  assign free = ~char_valid | char_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char_out   <= '0;
      char_valid <= 1'b0;
    end else if (load && free) begin
      char_out   <= load_data;
      char_valid <= 1'b1;
    end else if (char_ready) begin
      char_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/srec_emitter.sv
// Reads a byte region through the memory port and emits it as S3 records plus an S7 terminator.
module srec_emitter
  import srec_pkg::*;
#(
  parameter int unsigned BYTES_PER_REC = 16,
  parameter int unsigned MEM_LAT       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [31:0] byte_count,
  input  logic [31:0] entry_addr,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_access_size,
  output logic        mem_rw,
  input  logic [31:0] mem_data_in,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready
);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rec_addr_q, rec_addr_d;
  logic [31:0] remain_q, remain_d;
  logic [31:0] entry_q, entry_d;
  logic [7:0]  rec_len_q, rec_len_d;
  logic [7:0]  rec_left_q, rec_left_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  data_q, data_d;

  logic        load;
  logic [7:0]  load_data;
  logic        free;
  logic [7:0]  cnt_byte;
  logic [7:0]  cks;
  logic [31:0] hex_src;
  logic [2:0]  nib_i;
  logic [31:0] sh;
  logic        unused_mem_hi;

  assign unused_mem_hi   = ^mem_data_in[31:8];
  assign mem_address     = addr_q;
  assign mem_access_size = 2'b00;
  assign mem_rw          = 1'b1;
  assign busy            = (state_q != ST_IDLE);

  function automatic logic [7:0] rec_len_of(input logic [31:0] rem);
    return (rem < BYTES_PER_REC) ? rem[7:0] : 8'(BYTES_PER_REC);
  endfunction

  srec_char_reg u_char_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (load_data),
    .char_ready (char_ready),
    .char_out   (char_out),
    .char_valid (char_valid),
    .free       (free)
  );

  // Address hex digits: TERM places its 8 entry digits at idx 4..11, ADDR at idx 0..7.
  // On odd digits the low byte of the shifted word is the just-completed address byte.
  always_comb begin
    cnt_byte = rec_len_q + 8'd5;
    cks      = srec_cksum(acc_q);
    hex_src  = (state_q == ST_TERM) ? entry_q : rec_addr_q;
    nib_i    = (state_q == ST_TERM) ? (idx_q[2:0] ^ 3'b100) : idx_q[2:0];
    sh       = hex_src >> {~nib_i, 2'b00};
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    rec_addr_d = rec_addr_q;
    remain_d   = remain_q;
    entry_d    = entry_q;
    rec_len_d  = rec_len_q;
    rec_left_d = rec_left_q;
    acc_d      = acc_q;
    data_d     = data_q;
    load       = 1'b0;
    load_data  = '0;
    done       = 1'b0;

    // Backpressure: nothing advances while a character is held and not accepted
    if (free) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_d     = start_addr;
            rec_addr_d = start_addr;
            remain_d   = byte_count;
            entry_d    = entry_addr;
            rec_len_d  = rec_len_of(byte_count);
            rec_left_d = rec_len_of(byte_count);
            load       = 1'b1;
            load_data  = ASCII_S;
            idx_d      = 4'd1;
            state_d    = (byte_count == '0) ? ST_TERM : ST_HDR;
          end
        end
        ST_HDR: begin
          load = 1'b1;
          if (idx_q == 4'd0) begin
            load_data = ASCII_S;
            idx_d     = 4'd1;
          end else begin
            load_data = ASCII_3;
            idx_d     = '0;
            state_d   = ST_CNT;
          end
        end
        ST_CNT: begin
          load = 1'b1;
          if (idx_q == 4'd0) begin
            load_data = hex_ascii(cnt_byte[7:4]);
            acc_d     = cnt_byte;
            idx_d     = 4'd1;
          end else begin
            load_data = hex_ascii(cnt_byte[3:0]);
            idx_d     = '0;
            state_d   = ST_ADDR;
          end
        end
        ST_ADDR: begin
          load      = 1'b1;
          load_data = hex_ascii(sh[3:0]);
          if (idx_q[0]) acc_d = acc_q + sh[7:0];
          if (idx_q == 4'd7) begin
            idx_d   = '0;
            state_d = ST_RD;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        ST_RD: begin
          if (idx_q == 4'(MEM_LAT)) begin
            data_d  = mem_data_in[7:0];
            idx_d   = '0;
            state_d = ST_DATA;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        ST_DATA: begin
          load = 1'b1;
          if (idx_q == 4'd0) begin
            load_data = hex_ascii(data_q[7:4]);
            idx_d     = 4'd1;
          end else begin
            load_data  = hex_ascii(data_q[3:0]);
            acc_d      = acc_q + data_q;
            addr_d     = addr_q + 32'd1;
            remain_d   = remain_q - 32'd1;
            rec_left_d = rec_left_q - 8'd1;
            idx_d      = '0;
            state_d    = (rec_left_q == 8'd1) ? ST_CK : ST_RD;
          end
        end
        ST_CK: begin
          load = 1'b1;
          if (idx_q == 4'd0) begin
            load_data = hex_ascii(cks[7:4]);
            idx_d     = 4'd1;
          end else begin
            load_data = hex_ascii(cks[3:0]);
            idx_d     = '0;
            state_d   = ST_EOL;
          end
        end
        ST_EOL: begin
          load      = 1'b1;
          load_data = ASCII_LF;
          idx_d     = '0;
          if (remain_q != '0) begin
            rec_addr_d = addr_q;
            rec_len_d  = rec_len_of(remain_q);
            rec_left_d = rec_len_of(remain_q);
            state_d    = ST_HDR;
          end else begin
            state_d = ST_TERM;
          end
        end
        ST_TERM: begin
          load  = 1'b1;
          idx_d = idx_q + 4'd1;
          case (idx_q)
            4'd0:  load_data = ASCII_S;
            4'd1:  load_data = ASCII_7;
            4'd2:  load_data = ASCII_0;
            4'd3: begin
              load_data = hex_ascii(4'h5);
              acc_d     = 8'h05;
            end
            4'd12: load_data = hex_ascii(cks[7:4]);
            4'd13: load_data = hex_ascii(cks[3:0]);
            4'd14: begin
              load_data = ASCII_LF;
              idx_d     = '0;
              state_d   = ST_FIN;
            end
            default: begin
              load_data = hex_ascii(sh[3:0]);
              if (idx_q[0]) acc_d = acc_q + sh[7:0];
            end
          endcase
        end
        ST_FIN: begin
          if (!char_valid) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      rec_addr_q <= '0;
      remain_q   <= '0;
      entry_q    <= '0;
      rec_len_q  <= '0;
      rec_left_q <= '0;
      acc_q      <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      rec_addr_q <= rec_addr_d;
      remain_q   <= remain_d;
      entry_q    <= entry_d;
      rec_len_q  <= rec_len_d;
      rec_left_q <= rec_left_d;
      acc_q      <= acc_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_srec_emitter.sv
// Directed bench for srec_emitter: fixed-stream checks plus an S-record parser for longer dumps.
module tb_srec_emitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] start_addr = '0;
  logic [31:0] byte_count = '0;
  logic [31:0] entry_addr = '0;
  logic        busy, done;
  logic [31:0] mem_address;
  logic [1:0]  mem_access_size;
  logic        mem_rw;
  logic [31:0] mem_data_in;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  logic [7:0] rx[$];
  logic [7:0] mem [256];
  logic [7:0] d1 = '0, d2 = '0;

  localparam string EXP1 = "S3098002000027BDFFE8A9\nS7058002000078\n";
  localparam string EXP0 = "S70500001234B4\n";

  srec_emitter #(.BYTES_PER_REC(16), .MEM_LAT(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .start_addr      (start_addr),
    .byte_count      (byte_count),
    .entry_addr      (entry_addr),
    .busy            (busy),
    .done            (done),
    .mem_address     (mem_address),
    .mem_access_size (mem_access_size),
    .mem_rw          (mem_rw),
    .mem_data_in     (mem_data_in),
    .char_out        (char_out),
    .char_valid      (char_valid),
    .char_ready      (char_ready)
  );

  always #5 clk = ~clk;

  // Two-cycle read latency memory; upper bits carry junk the DUT must ignore
  always @(posedge clk) begin
    d1 <= mem[mem_address[7:0]];
    d2 <= d1;
  end
  assign mem_data_in = {24'hA5C3E1, d2};

  always @(negedge clk) begin
    if (!rst) begin
      if (char_valid && char_ready) rx.push_back(char_out);
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int p);
    if (p < rx.size()) return rx[p];
    return 8'h00;
  endfunction

  task automatic get_byte(inout int p, output logic [7:0] b, inout int bad);
    logic [7:0] c;
    b = '0;
    for (int k = 0; k < 2; k++) begin
      c = rx_at(p);
      p++;
      if (c >= 8'h30 && c <= 8'h39) b = {b[3:0], 4'(c - 8'h30)};
      else if (c >= 8'h41 && c <= 8'h46) b = {b[3:0], 4'(c - 8'h37)};
      else begin
        b = {b[3:0], 4'h0};
        bad++;
      end
    end
  endtask

  task automatic do_start(input logic [31:0] sa, input logic [31:0] bc, input logic [31:0] ea);
    @(posedge clk); #1;
    start_addr = sa;
    byte_count = bc;
    entry_addr = ea;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input string name, input bit rnd, input int budget);
    int d0 = done_cnt;
    int i  = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clk); #1;
      if (rnd) char_ready = 1'($urandom_range(0, 1));
      i++;
    end
    char_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_idle"}, {31'b0, busy}, 0);
  endtask

  task automatic wait_chars(input string name, input int n, input bit need_valid);
    int i = 0;
    while (!(rx.size() >= n && (char_valid || !need_valid)) && i < 2000) begin
      @(posedge clk); #1;
      i++;
    end
    check({name, "_reached"}, {31'b0, (rx.size() >= n)}, 1);
  endtask

  task automatic compare_stream(input string name, input string exp);
    check({name, "_len"}, rx.size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      check($sformatf("%s_char%0d", name, i), {24'h0, rx_at(i)}, {24'h0, exp[i]});
  endtask

  task automatic parse_dump(input string name, input logic [31:0] base, input int nbytes,
                            input logic [31:0] entry, input int exp_recs);
    int p = 0, total = 0, recs = 0, bad = 0, ndata, exp_n;
    bit seen_term = 1'b0;
    logic [7:0] typ, cnt, sum, b;
    logic [31:0] a;
    while (p < rx.size() && !seen_term && recs < 40) begin
      check({name, "_S"}, {24'h0, rx_at(p)}, 32'h53);
      typ = rx_at(p + 1);
      p += 2;
      get_byte(p, cnt, bad);
      sum = cnt;
      a = '0;
      for (int k = 0; k < 4; k++) begin
        get_byte(p, b, bad);
        a = {a[23:0], b};
        sum += b;
      end
      if (typ == 8'h33) begin
        recs++;
        check({name, "_rec_addr"}, a, base + 32'(total));
        exp_n = (nbytes - total < 16) ? nbytes - total : 16;
        check({name, "_rec_count"}, {24'h0, cnt}, exp_n + 5);
        ndata = int'(cnt) - 5;
        for (int k = 0; k < ndata && k < 250; k++) begin
          get_byte(p, b, bad);
          sum += b;
          a = base + 32'(total);
          check($sformatf("%s_data%0d", name, total), {24'h0, b}, {24'h0, mem[a[7:0]]});
          total++;
        end
      end else begin
        check({name, "_term_type"}, {24'h0, typ}, 32'h37);
        check({name, "_term_count"}, {24'h0, cnt}, 32'h05);
        check({name, "_term_addr"}, a, entry);
        seen_term = 1'b1;
      end
      get_byte(p, b, bad);
      check({name, "_cksum"}, {24'h0, b}, {24'h0, ~sum});
      check({name, "_lf"}, {24'h0, rx_at(p)}, 32'h0A);
      p++;
    end
    check({name, "_term_seen"}, {31'b0, seen_term}, 1);
    check({name, "_total"}, total, nbytes);
    check({name, "_records"}, recs, exp_recs);
    check({name, "_trailing"}, p, rx.size());
    check({name, "_hex_ok"}, bad, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h27;
    mem[1] = 8'hBD;
    mem[2] = 8'hFF;
    mem[3] = 8'hE8;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_valid", {31'b0, char_valid}, 0);
    check("rst_char", {24'h0, char_out}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_rw", {31'b0, mem_rw}, 1);
    check("rst_size", {30'b0, mem_access_size}, 0);
    rst = 1'b0;

    // Single record, first-character latency
    rx.delete();
    do_start(32'h80020000, 32'd4, 32'h80020000);
    check("lat_busy", {31'b0, busy}, 1);
    check("lat_valid", {31'b0, char_valid}, 1);
    check("lat_char", {24'h0, char_out}, 32'h53);
    run_until_done("single", 1'b0, 2000);
    compare_stream("single", EXP1);

    // Two records; a start pulse while busy must be ignored
    rx.delete();
    do_start(32'h80020000, 32'd20, 32'h80020000);
    repeat (10) @(posedge clk);
    #1;
    start_addr = 32'h00000040;
    byte_count = 32'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    run_until_done("multi", 1'b0, 3000);
    parse_dump("multi", 32'h80020000, 20, 32'h80020000, 2);
    check("multi_end_addr", mem_address, 32'h80020014);

    // Backpressure while the first data byte's low digit is pending
    rx.delete();
    do_start(32'h80020000, 32'd4, 32'h80020000);
    wait_chars("bp", 12, 1'b1);
    char_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_char%0d", i), {24'h0, char_out}, {24'h0, EXP1[12]});
      check($sformatf("bp_valid%0d", i), {31'b0, char_valid}, 1);
      check($sformatf("bp_addr%0d", i), mem_address, 32'h80020000);
      @(posedge clk); #1;
    end
    char_ready = 1'b1;
    run_until_done("bp", 1'b0, 2000);
    compare_stream("bp", EXP1);

    // Zero length: terminator only
    rx.delete();
    do_start(32'h00000100, 32'd0, 32'h00001234);
    run_until_done("zero", 1'b0, 1000);
    compare_stream("zero", EXP0);

    // Reset during the address field, then a clean dump
    rx.delete();
    do_start(32'h80020000, 32'd4, 32'h80020000);
    wait_chars("mid_rst", 6, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_done", {31'b0, done}, 0);
    check("mid_rst_valid", {31'b0, char_valid}, 0);
    check("mid_rst_char", {24'h0, char_out}, 0);
    check("mid_rst_addr", mem_address, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rx.delete();
    do_start(32'h80020000, 32'd4, 32'h80020000);
    run_until_done("after_rst", 1'b0, 2000);
    compare_stream("after_rst", EXP1);

    // Address wrap across 0xFFFFFFFF
    rx.delete();
    do_start(32'hFFFFFFFE, 32'd4, 32'h00000000);
    run_until_done("wrap", 1'b0, 2000);
    parse_dump("wrap", 32'hFFFFFFFE, 4, 32'h00000000, 1);
    check("wrap_end_addr", mem_address, 32'h00000002);

    // Round trip of 64 bytes under random sink stalls
    rx.delete();
    do_start(32'h00001000, 32'd64, 32'h00001000);
    run_until_done("round", 1'b1, 8000);
    parse_dump("round", 32'h00001000, 64, 32'h00001000, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
